progmem_arbiter: RTL and testbench

Two-port arbiter that shares the single program-memory slave between the CPU instruction-fetch master and the data/loader master. It sits between the interconnect and the program-memory wrapper and exposes the same Avalon-style `ctrl_*` protocol on both sides. Arbitration is round-robin at transfer granularity, one transfer in flight at a time. The block enforces one idle bus cycle between consecutive memory transfers.

---
 rtl/progmem_arbiter_pkg.sv | 12 +
 rtl/progmem_arbiter.sv | 107 ++++++++++
 tb/tb_progmem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/progmem_arbiter_pkg.sv
// Shared definitions for the program-memory arbiter: port count and FSM encoding.
package progmem_arbiter_pkg;

  localparam int unsigned ARB_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/progmem_arbiter.sv
// Round-robin two-master arbiter in front of the program memory; one transfer in
// flight, with a forced idle bus cycle between consecutive transfers.
module progmem_arbiter
  import progmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [ADDR_W-1:0]     s0_address,
  input  logic                  s0_read,
  input  logic                  s0_write,
  input  logic [DATA_W/8-1:0]   s0_byteenable,
  input  logic [DATA_W-1:0]     s0_writedata,
  output logic [DATA_W-1:0]     s0_readdata,
  output logic                  s0_waitrequest,

  input  logic [ADDR_W-1:0]     s1_address,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0]     s1_writedata,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_waitrequest,

  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  input  logic [DATA_W-1:0]     mem_readdata,
  input  logic                  mem_waitrequest
);

  arb_state_t           state;
  logic                 last;
  logic [ARB_PORTS-1:0] req;

  assign req = {s1_read | s1_write, s0_read | s0_write};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // s0 wins when alone, or on a tie when s1 had the previous grant
          if (req[0] && (!req[1] || last)) state <= GNT0;
          else if (req[1])                 state <= GNT1;
        end
        GNT0: begin
          if (!req[0]) begin
            state <= IDLE;
          end else if (!mem_waitrequest) begin
            last  <= 1'b0;
            state <= IDLE;
          end
        end
        GNT1: begin
          if (!req[1]) begin
            state <= IDLE;
          end else if (!mem_waitrequest) begin
            last  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s0_readdata = mem_readdata;
  assign s1_readdata = mem_readdata;

  always_comb begin
    mem_address    = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    s0_waitrequest = req[0];
    s1_waitrequest = req[1];
    case (state)
      GNT0: begin
        mem_address    = s0_address;
        mem_read       = s0_read;
        mem_write      = s0_write;
        mem_byteenable = s0_byteenable;
        mem_writedata  = s0_writedata;
        s0_waitrequest = mem_waitrequest;
      end
      GNT1: begin
        mem_address    = s1_address;
        mem_read       = s1_read;
        mem_write      = s1_write;
        mem_byteenable = s1_byteenable;
        mem_writedata  = s1_writedata;
        s1_waitrequest = mem_waitrequest;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_progmem_arbiter.sv
// Bench for progmem_arbiter: directed timing scenarios, then two random masters
// checked by a completion-driven scoreboard against a reference memory.
module tb_progmem_arbiter;

  typedef struct {
    bit          rd;
    logic [12:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] s0_address = '0, s1_address = '0;
  logic        s0_read = 1'b0, s0_write = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
  logic [3:0]  s0_byteenable = '0, s1_byteenable = '0;
  logic [31:0] s0_writedata = '0, s1_writedata = '0;
  logic [31:0] s0_readdata, s1_readdata;
  logic        s0_waitrequest, s1_waitrequest;
  logic [12:0] mem_address;
  logic        mem_read, mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_waitrequest;

  int n_vec = 0;
  int n_err = 0;

  progmem_arbiter #(.ADDR_W(13), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_byteenable(s0_byteenable), .s0_writedata(s0_writedata),
    .s0_readdata(s0_readdata), .s0_waitrequest(s0_waitrequest),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_waitrequest(s1_waitrequest),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory slave model: stalls k_cur cycles per transfer, then completes.
  logic [31:0] mem_arr [0:8191];
  logic [31:0] ref_mem [0:8191];
  int cnt = 0;
  int k_cur = 2;
  bit rand_k = 1'b0;

  assign mem_waitrequest = (cnt < k_cur);
  assign mem_readdata    = mem_arr[mem_address];

  always @(posedge clk) begin
    if (mem_read || mem_write) begin
      if (cnt >= k_cur) begin
        if (mem_write)
          for (int b = 0; b < 4; b++)
            if (mem_byteenable[b]) mem_arr[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        cnt <= 0;
        if (rand_k) k_cur <= $urandom_range(0, 3);
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  // Scoreboard: per-port expected queues, popped at each observed completion.
  txn_t q0[$], q1[$];
  bit   sb_en = 1'b0;
  bit   gap_due = 1'b0;
  bit   must_next [2];
  wire  s0_req = s0_read | s0_write;
  wire  s1_req = s1_read | s1_write;

  always @(negedge clk) begin
    if (sb_en) begin
      bit   c0, c1;
      int   p;
      txn_t t;
      c0 = s0_req && !s0_waitrequest;
      c1 = s1_req && !s1_waitrequest;
      if (gap_due) begin
        check("bus_gap", {62'd0, mem_read, mem_write}, 64'd0);
        gap_due = 1'b0;
      end
      if (c0 && c1) check("dual_complete", 1, 0);
      if (c0 || c1) begin
        p = c0 ? 0 : 1;
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
          check("unexpected_complete", 1, 0);
        end else begin
          t = (p == 0) ? q0.pop_front() : q1.pop_front();
          check("sb_addr", mem_address, t.addr);
          check("sb_rw", {62'd0, mem_read, mem_write}, {62'd0, t.rd, !t.rd});
          if (t.rd) begin
            check("sb_rdata", (p == 0) ? s0_readdata : s1_readdata, ref_mem[t.addr]);
          end else begin
            check("sb_be", mem_byteenable, t.be);
            check("sb_wdata", mem_writedata, t.data);
            for (int b = 0; b < 4; b++)
              if (t.be[b]) ref_mem[t.addr][8*b +: 8] = t.data[8*b +: 8];
          end
          check("fairness", must_next[1-p], 0);
          must_next[p]   = 1'b0;
          must_next[1-p] = (p == 0) ? s1_req : s0_req;
          gap_due = 1'b1;
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input int p, input bit act, input txn_t t);
    if (p == 0) begin
      s0_read = act & t.rd;  s0_write = act & !t.rd;
      s0_address = t.addr;   s0_byteenable = t.be;  s0_writedata = t.data;
    end else begin
      s1_read = act & t.rd;  s1_write = act & !t.rd;
      s1_address = t.addr;   s1_byteenable = t.be;  s1_writedata = t.data;
    end
  endtask

  task automatic wait_done(input int p, input logic [12:0] exp_addr);
    bit d = 1'b0;
    txn_t z = '{rd: 1'b0, addr: '0, be: '0, data: '0};
    for (int i = 0; i < 40 && !d; i++) begin
      smp();
      if (p == 0 ? (s0_req && !s0_waitrequest) : (s1_req && !s1_waitrequest)) begin
        d = 1'b1;
        check($sformatf("done_addr_s%0d", p), mem_address, exp_addr);
      end else begin
        next();
      end
    end
    check($sformatf("done_s%0d", p), d, 1);
    next();
    drive(p, 1'b0, z);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) next();
    rst_n = 1'b1;
    next();
  endtask

  task automatic master(input int p, input int n);
    txn_t t;
    bit   done;
    int   waited;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) next();
      t.rd   = 1'($urandom_range(0, 1));
      t.addr = ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'($urandom_range(0, 15));
      t.be   = 4'($urandom);
      t.data = $urandom;
      if (p == 0) q0.push_back(t); else q1.push_back(t);
      drive(p, 1'b1, t);
      done = 1'b0;
      waited = 0;
      while (!done && waited < 60) begin
        smp();
        if (!((p == 0) ? s0_waitrequest : s1_waitrequest)) done = 1'b1;
        else waited++;
      end
      check($sformatf("m%0d_complete", p), done, 1);
      next();
      drive(p, 1'b0, t);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int done_cnt, gap, cyc;

    for (int i = 0; i < 8192; i++) mem_arr[i] = 32'hA5A50000 | 32'(i);
    mem_arr[13'h010] = 32'hDEADBEEF;
    mem_arr[13'h1FFF] = 32'hAABBCCDD;

    // Reset values
    repeat (2) smp();
    check("rst_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
    check("rst_mem_be", mem_byteenable, 4'h0);
    check("rst_mem_addr", mem_address, 13'h0);
    check("rst_mem_wdata", mem_writedata, 32'h0);
    check("rst_readdata", s1_readdata, 32'hA5A50000);
    s0_read = 1'b1;
    #1 check("rst_wait_eq_req", {62'd0, s0_waitrequest, s1_waitrequest}, 64'd2);
    s0_read = 1'b0;
    rst_n = 1'b1;
    next();

    // Single read with 2-cycle memory stall
    s0_read = 1'b1; s0_address = 13'h010;
    smp(); check("rd_T_memread", mem_read, 0); check("rd_T_wait", s0_waitrequest, 1);
    next(); smp(); check("rd_T1_memread", mem_read, 1); check("rd_T1_addr", mem_address, 13'h010);
    check("rd_T1_wait", s0_waitrequest, 1);
    next(); smp(); check("rd_T2_wait", s0_waitrequest, 1);
    next(); smp(); check("rd_T3_wait", s0_waitrequest, 0); check("rd_T3_data", s0_readdata, 32'hDEADBEEF);
    next(); s0_read = 1'b0;
    smp(); check("rd_gap", mem_read, 0);

    // Simultaneous reads after reset: s0 first, s1 two cycles after s0 completes
    do_reset();
    s0_read = 1'b1; s0_address = 13'h020; s1_read = 1'b1; s1_address = 13'h030;
    smp(); check("sim_T_wait", {62'd0, s0_waitrequest, s1_waitrequest}, 64'd3);
    next(); smp(); check("sim_T1_addr", mem_address, 13'h020); check("sim_T1_s1wait", s1_waitrequest, 1);
    next(); next(); smp(); check("sim_T3_s0done", s0_waitrequest, 0);
    next(); s0_read = 1'b0;
    smp(); check("sim_T4_gap", mem_read, 0); check("sim_T4_s1wait", s1_waitrequest, 1);
    next(); smp(); check("sim_T5_memread", mem_read, 1); check("sim_T5_addr", mem_address, 13'h030);
    wait_done(1, 13'h030);

    // Round-robin under continuous requests from both ports
    s0_read = 1'b1; s0_address = 13'h100; s1_read = 1'b1; s1_address = 13'h200;
    done_cnt = 0; gap = 0; cyc = 0;
    while (done_cnt < 6 && cyc < 80) begin
      smp(); cyc++;
      if (mem_read && !mem_waitrequest) begin
        check("rr_order", mem_address, (done_cnt % 2 == 0) ? 13'h100 : 13'h200);
        if (done_cnt > 0) check("rr_gap", gap, 1);
        done_cnt++; gap = 0;
      end else if (!mem_read) begin
        gap++;
      end
      if (done_cnt < 6) next();
    end
    check("rr_count", done_cnt, 6);
    next(); s0_read = 1'b0; s1_read = 1'b0;

    // Write passthrough on s1
    s1_write = 1'b1; s1_address = 13'h1FFF; s1_byteenable = 4'b0101; s1_writedata = 32'h12345678;
    for (int c = 1; c <= 3; c++) begin
      next(); smp();
      check("wr_mem_write", mem_write, 1);
      check("wr_addr", mem_address, 13'h1FFF);
      check("wr_be", mem_byteenable, 4'b0101);
      check("wr_data", mem_writedata, 32'h12345678);
      check("wr_wait_mirror", s1_waitrequest, mem_waitrequest);
    end
    check("wr_T3_done", s1_waitrequest, 0);
    next(); s1_write = 1'b0; s1_byteenable = '0;
    smp(); check("wr_memcontent", mem_arr[13'h1FFF], 32'hAA34CC78);

    // Withdrawn request: s0 drops mid-grant, last stays at s1 so s0 wins the re-tie
    next();
    s0_read = 1'b1; s0_address = 13'h040;
    smp(); next();
    s1_read = 1'b1; s1_address = 13'h050;
    smp(); check("wd_T1_addr", mem_address, 13'h040);
    next(); s0_read = 1'b0;
    smp(); check("wd_T2_memread", mem_read, 0);
    next(); s0_read = 1'b1;
    smp(); check("wd_T3_idle", mem_read, 0); check("wd_T3_s1wait", s1_waitrequest, 1);
    next(); smp(); check("wd_T4_regrant_s0", mem_address, 13'h040);
    wait_done(0, 13'h040);
    wait_done(1, 13'h050);

    // Reset during a GNT1 stall
    s1_read = 1'b1; s1_address = 13'h070;
    next(); s0_read = 1'b1; s0_address = 13'h060;
    smp(); check("rs_T1_addr", mem_address, 13'h070);
    next(); #2 rst_n = 1'b0;
    #1 check("rs_memrw_drop", {62'd0, mem_read, mem_write}, 64'd0);
    check("rs_addr_idle", mem_address, 13'h0); check("rs_s1wait", s1_waitrequest, 1);
    next(); rst_n = 1'b1;
    next(); smp(); check("rs_s0_first", mem_address, 13'h060);
    wait_done(0, 13'h060);
    wait_done(1, 13'h070);

    // Randomized traffic with varying memory stall
    for (int i = 0; i < 8192; i++) begin
      v = $urandom;
      mem_arr[i] = v;
      ref_mem[i] = v;
    end
    must_next[0] = 1'b0; must_next[1] = 1'b0;
    rand_k = 1'b1;
    next();
    sb_en = 1'b1;
    fork
      master(0, 40);
      master(1, 40);
    join
    repeat (4) next();
    sb_en = 1'b0;
    check("sb_q0_empty", q0.size(), 0);
    check("sb_q1_empty", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
